// File: rtl/encoder8to3_arbiter_if.sv
// Handshake bundle between the encoder/arbiter and its consumer.
// The master side (request source plus consumer) drives en/req/ack.
// The slave side (the arbiter) returns code/valid/pending/multi.
interface encoder8to3_arbiter_if;
    logic       en;
    logic [7:0] req;
    logic       ack;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pending;
    logic       multi;

    modport master (
        output en,
        output req,
        output ack,
        input  code,
        input  valid,
        input  pending,
        input  multi
    );

    modport slave (
        input  en,
        input  req,
        input  ack,
        output code,
        output valid,
        output pending,
        output multi
    );
endinterface

// File: rtl/encoder8to3_arbiter.sv
// Registered 8-to-3 priority encoder with request capture and a valid/ack
// handshake.
//
// Request lines are OR-ed into a pending register every enabled clock. While
// idle, one pending index is selected and presented as a 3-bit code. The code
// is held until the consumer acks it; the acked bit is then cleared. A
// simultaneous new request for the same bit wins over the clear.
//
// Optional build macro ENC_ROUND_ROBIN_EN:
//   undefined - fixed priority chosen by HIGH_FIRST (1: bit 7 highest,
//               0: bit 0 highest); no pointer register exists.
//   defined   - round-robin selection starting after the last acked index
//               (pointer resets to 7, so bit 0 is searched first); HIGH_FIRST
//               is ignored.
module encoder8to3_arbiter #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    encoder8to3_arbiter_if.slave        bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] pending_q;
    logic [7:0] pending_d;
    logic [2:0] code_q;
    logic [2:0] code_d;
    logic       valid_q;
    logic       valid_d;
    logic       multi_q;
    logic       multi_d;

    logic       ack_s;
    logic       grant_s;
    logic [7:0] clr_mask_s;
    logic [7:0] set_mask_s;
    logic [2:0] sel_s;

    // Highest set index of vec (0 when vec is empty).
    function automatic logic [2:0] pick_high(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (vec[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Lowest set index of vec (0 when vec is empty).
    function automatic logic [2:0] pick_low(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // True when two or more bits of vec are set: clearing the lowest set
    // bit leaves something behind.
    function automatic logic more_than_one(input logic [7:0] vec);
        return ((vec & (vec - 8'd1)) != 8'd0);
    endfunction

`ifdef ENC_ROUND_ROBIN_EN
    // First set index found searching upward from ptr+1 with wrap-around.
    // The loop runs from the farthest offset to the nearest so the nearest
    // hit is the one that survives; offset 8 (ptr itself) is the last resort.
    function automatic logic [2:0] pick_rr(input logic [7:0] vec,
                                           input logic [2:0] ptr);
        logic [2:0] idx;
        logic [2:0] probe;
        idx = 3'd0;
        for (int k = 8; k >= 1; k--) begin
            probe = ptr + 3'(k);
            if (vec[probe]) begin
                idx = probe;
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [2:0] ptr_q;
    logic [2:0] ptr_d;

    // Round-robin selection from the last acked index.
    always_comb begin
        sel_s = pick_rr(pending_q, ptr_q);
    end

    // Pointer follows the code each time the consumer accepts it.
    always_comb begin
        ptr_d = ptr_q;
        if (ack_s) begin
            ptr_d = code_q;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Last-granted pointer register; reset value makes bit 0 the first pick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 3'd7;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed-priority selection, direction chosen at elaboration.
    always_comb begin
        if (HIGH_FIRST) begin
            sel_s = pick_high(pending_q);
        end else begin
            sel_s = pick_low(pending_q);
        end
    end
`endif

    // Handshake qualifiers: ack counts only while a grant is presented,
    // and a new grant needs enable plus something pending.
    always_comb begin
        ack_s      = (state_q == ST_GRANT) && bus.ack;
        grant_s    = (state_q == ST_IDLE) && bus.en && (pending_q != 8'h00);
        clr_mask_s = ack_s ? (8'h01 << code_q) : 8'h00;
        set_mask_s = bus.en ? bus.req : 8'h00;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> GRANT on a new grant, GRANT -> IDLE on ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (ack_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output/datapath next values: capture requests (set beats clear),
    // latch code and multi at grant time, hold them throughout GRANT.
    always_comb begin
        pending_d = (pending_q & ~clr_mask_s) | set_mask_s;
        code_d    = code_q;
        multi_d   = multi_q;
        valid_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    code_d  = sel_s;
                    multi_d = more_than_one(pending_q);
                    valid_d = 1'b1;
                end else begin
                    valid_d = 1'b0;
                end
            end
            ST_GRANT: begin
                if (ack_s) begin
                    valid_d = 1'b0;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // Registered outputs and pending register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= 8'h00;
            code_q    <= 3'd0;
            valid_q   <= 1'b0;
            multi_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            multi_q   <= multi_d;
        end
    end

    assign bus.code    = code_q;
    assign bus.valid   = valid_q;
    assign bus.pending = pending_q;
    assign bus.multi   = multi_q;

endmodule

// File: tb/tb_encoder8to3_arbiter.sv
// Self-checking bench for encoder8to3_arbiter: two instances (bit 7 first and
// bit 0 first) share one stimulus stream and are compared every cycle against
// a behavioural model, after directed scenarios and a randomized run.
module tb_encoder8to3_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_s;
    logic [7:0] req_s;
    logic       ack_s;

    encoder8to3_arbiter_if bus_hi ();
    encoder8to3_arbiter_if bus_lo ();

    assign bus_hi.en  = en_s;
    assign bus_hi.req = req_s;
    assign bus_hi.ack = ack_s;
    assign bus_lo.en  = en_s;
    assign bus_lo.req = req_s;
    assign bus_lo.ack = ack_s;

    encoder8to3_arbiter #(.HIGH_FIRST(1'b1)) u_dut_hi (
        .clk (clk),
        .rst (rst),
        .bus (bus_hi)
    );

    encoder8to3_arbiter #(.HIGH_FIRST(1'b0)) u_dut_lo (
        .clk (clk),
        .rst (rst),
        .bus (bus_lo)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, index 0 = high-first, 1 = low-first.
    int m_pend  [2];
    int m_code  [2];
    int m_valid [2];
    int m_multi [2];
    int m_ptr   [2];

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Index chosen from set p: fixed priority via log2 arithmetic, or the
    // first set bit found walking upward from ptr+1.
    function automatic int pick(input int p, input int high_first, input int ptr);
`ifdef ENC_ROUND_ROBIN_EN
        for (int k = 1; k <= 8; k++) begin
            if (p[(ptr + k) % 8]) return (ptr + k) % 8;
        end
        return 0;
`else
        if (high_first != 0) return $clog2(p + 1) - 1;
        return $clog2(p & (-p));
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pend[i]  = 0;
            m_code[i]  = 0;
            m_valid[i] = 0;
            m_multi[i] = 0;
            m_ptr[i]   = 7;
        end
    endtask

    task automatic model_step(input int i);
        int old_p;
        int clr;
        old_p = m_pend[i];
        clr   = (m_valid[i] != 0 && ack_s) ? (1 << m_code[i]) : 0;
        m_pend[i] = (old_p & ~clr) | (en_s ? int'(req_s) : 0);
        if (m_valid[i] != 0) begin
            if (ack_s) begin
                m_valid[i] = 0;
                m_ptr[i]   = m_code[i];
            end
        end else if (en_s && old_p != 0) begin
            m_code[i]  = pick(old_p, (i == 0) ? 1 : 0, m_ptr[i]);
            m_multi[i] = ($countones(old_p) > 1) ? 1 : 0;
            m_valid[i] = 1;
        end
    endtask

    task automatic compare_all();
        check_val("hi.pending", bus_hi.pending, m_pend[0]);
        check_val("hi.valid",   bus_hi.valid,   m_valid[0]);
        check_val("hi.code",    bus_hi.code,    m_code[0]);
        check_val("hi.multi",   bus_hi.multi,   m_multi[0]);
        check_val("lo.pending", bus_lo.pending, m_pend[1]);
        check_val("lo.valid",   bus_lo.valid,   m_valid[1]);
        check_val("lo.code",    bus_lo.code,    m_code[1]);
        check_val("lo.multi",   bus_lo.multi,   m_multi[1]);
    endtask

    // One clock: drive inputs, let the edge happen, update model, compare.
    task automatic cycle(input logic en, input logic [7:0] req, input logic ack);
        en_s  = en;
        req_s = req;
        ack_s = ack;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_all();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic pulse_reset(input logic [7:0] req);
        en_s  = 1'b1;
        req_s = req;
        ack_s = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check_val("rst.valid_now", bus_hi.valid, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        en_s  = 1'b1;
        req_s = 8'hFF;
        ack_s = 1'b0;
        model_reset();
        #3;
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-grant with every request line high.
        cycle(1'b1, 8'h0C, 1'b0);
        cycle(1'b1, 8'h00, 1'b0);
        pulse_reset(8'hFF);
        check_val("rst.pending", bus_hi.pending, 32'h00);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h00, 1'b0);
        check_val("idle.valid", bus_hi.valid, 32'd0);

`ifndef ENC_ROUND_ROBIN_EN
        // Single request.
        cycle(1'b1, 8'h20, 1'b0);
        check_val("single.pending", bus_hi.pending, 32'h20);
        check_val("single.valid_early", bus_hi.valid, 32'd0);
        cycle(1'b1, 8'h00, 1'b0);
        check_val("single.valid", bus_hi.valid, 32'd1);
        check_val("single.code", bus_hi.code, 32'd5);
        check_val("single.multi", bus_hi.multi, 32'd0);
        cycle(1'b1, 8'h00, 1'b1);
        check_val("single.ack_valid", bus_hi.valid, 32'd0);
        check_val("single.ack_pending", bus_hi.pending, 32'h00);

        // Priority order 7, 4, 0 (high-first) and 0, 4, 7 (low-first).
        cycle(1'b1, 8'h91, 1'b0);
        cycle(1'b1, 8'h00, 1'b0);
        check_val("prio.hi_code1", bus_hi.code, 32'd7);
        check_val("prio.hi_multi1", bus_hi.multi, 32'd1);
        check_val("prio.lo_code1", bus_lo.code, 32'd0);
        cycle(1'b1, 8'h00, 1'b1);
        check_val("prio.bubble1", bus_hi.valid, 32'd0);
        cycle(1'b1, 8'h00, 1'b0);
        check_val("prio.hi_code2", bus_hi.code, 32'd4);
        check_val("prio.hi_multi2", bus_hi.multi, 32'd1);
        check_val("prio.lo_code2", bus_lo.code, 32'd4);
        cycle(1'b1, 8'h00, 1'b1);
        check_val("prio.bubble2", bus_hi.valid, 32'd0);
        cycle(1'b1, 8'h00, 1'b0);
        check_val("prio.hi_code3", bus_hi.code, 32'd0);
        check_val("prio.hi_multi3", bus_hi.multi, 32'd0);
        check_val("prio.lo_code3", bus_lo.code, 32'd7);
        cycle(1'b1, 8'h00, 1'b1);

        // Hold without ack, then ack together with a new req[3].
        cycle(1'b1, 8'h08, 1'b0);
        cycle(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'h00, 1'b0);
            check_val("hold.code", bus_hi.code, 32'd3);
            check_val("hold.valid", bus_hi.valid, 32'd1);
        end
        cycle(1'b1, 8'h08, 1'b1);
        check_val("setwins.valid", bus_hi.valid, 32'd0);
        check_val("setwins.pending", bus_hi.pending, 32'h08);
        cycle(1'b1, 8'h00, 1'b0);
        check_val("setwins.regrant", bus_hi.code, 32'd3);
        check_val("setwins.revalid", bus_hi.valid, 32'd1);
        cycle(1'b1, 8'h00, 1'b1);

        // Enable gating.
        cycle(1'b0, 8'h02, 1'b0);
        check_val("en.no_capture", bus_hi.pending, 32'h00);
        cycle(1'b1, 8'h14, 1'b0);
        cycle(1'b1, 8'h00, 1'b0);
        check_val("en.grant_hi", bus_hi.code, 32'd4);
        check_val("en.grant_lo", bus_lo.code, 32'd2);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h01, 1'b1);
        check_val("en.ack_valid", bus_hi.valid, 32'd0);
        check_val("en.ack_pending", bus_hi.pending, 32'h04);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 1'b0);
            check_val("en.no_grant", bus_hi.valid, 32'd0);
        end
        cycle(1'b1, 8'h00, 1'b0);
        check_val("en.resume_code", bus_hi.code, 32'd2);
        cycle(1'b1, 8'h00, 1'b1);
`else
        // Round robin alternates 0, 7, 0, 7 with both lines held high.
        cycle(1'b1, 8'h81, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 8'h81, 1'b0);
            check_val("rr.code", bus_hi.code, (i % 2 == 0) ? 32'd0 : 32'd7);
            cycle(1'b1, 8'h81, 1'b1);
        end
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b1, 8'h00, 1'b1);
`endif

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            logic       r_en;
            logic [7:0] r_req;
            logic       r_ack;
            r_en  = ($urandom_range(0, 7) != 0);
            r_req = 8'($urandom() & $urandom() & $urandom());
            r_ack = ($urandom_range(0, 2) == 0);
            if (n % 450 == 449) begin
                pulse_reset(8'($urandom()));
            end else begin
                cycle(r_en, r_req, r_ack);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
